// File: rtl/spi_arb_pkg.sv
// Shared constants and state encoding for the SPI transaction arbiter.
// Delay counter and byte-length widths live here so all users agree.
package spi_arb_pkg;

   localparam int LEN_W = 3;
   localparam int CNT_W = 16;

   localparam int DEF_CS_SETUP_CLKS  = 500;
   localparam int DEF_INTERBYTE_CLKS = 300;
   localparam int DEF_CS_HOLD_CLKS   = 800;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SEND  = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;
   localparam logic [2:0] ST_HOLD  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_SETUP = ST_SETUP,
      S_SEND  = ST_SEND,
      S_WAIT  = ST_WAIT,
      S_GAP   = ST_GAP,
      S_HOLD  = ST_HOLD
   } state_e;

endpackage

// File: rtl/spi_txn_arbiter_rr_picker.sv
// Combinational round-robin select: first requester strictly after
// the last-grant pointer, wrapping back to client 0.
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Search above the pointer first, then wrap to the low clients
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (IW'(i) > ptr)) begin
            gnt[i] = 1'b1;
            idx    = IW'(i);
            any    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req[i]) begin
            gnt[i] = 1'b1;
            idx    = IW'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI_Master byte interface between several CS-framed
// clients, granting whole transactions round-robin with CS delays.
module spi_txn_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_CLIENTS    = 2,
   parameter int CS_SETUP_CLKS  = DEF_CS_SETUP_CLKS,
   parameter int INTERBYTE_CLKS = DEF_INTERBYTE_CLKS,
   parameter int CS_HOLD_CLKS   = DEF_CS_HOLD_CLKS
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_CLIENTS-1:0]       REQ,
   input  logic [3*NUM_CLIENTS-1:0]     LEN,
   input  logic [8*NUM_CLIENTS-1:0]     TX_BYTE,
   output logic [NUM_CLIENTS-1:0]       GNT,
   output logic [2:0]                   BYTE_INDEX,
   output logic [NUM_CLIENTS-1:0]       RX_DV,
   output logic [7:0]                   RX_BYTE,
   output logic [NUM_CLIENTS-1:0]       DONE,
   output logic [NUM_CLIENTS-1:0]       CS_n,
   output logic [7:0]                   SPI_TX_BYTE,
   output logic                         SPI_TX_DV,
   input  logic                         SPI_TX_READY,
   input  logic                         SPI_RX_DV,
   input  logic [7:0]                   SPI_RX_BYTE
);

   localparam int N  = NUM_CLIENTS;
   localparam int IW = $clog2(N);

   localparam logic [CNT_W-1:0] SETUP_CNT = CNT_W'(CS_SETUP_CLKS);
   localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(INTERBYTE_CLKS);
   localparam logic [CNT_W-1:0] HOLD_CNT  = CNT_W'(CS_HOLD_CLKS);

   state_e             state_q, state_d;
   logic [N-1:0]       gnt_q, gnt_d;
   logic [N-1:0]       cs_n_q, cs_n_d;
   logic [N-1:0]       rx_dv_q, rx_dv_d;
   logic [N-1:0]       done_q, done_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [7:0]         spi_tx_byte_q, spi_tx_byte_d;
   logic [7:0]         rx_byte_q, rx_byte_d;
   logic               spi_tx_dv_q, spi_tx_dv_d;

   logic [N-1:0]       pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic [7:0]         tx_sel;
   logic [LEN_W-1:0]   pick_len;

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .req (REQ),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Per-client muxes: granted TX byte and the winner's length
   always_comb begin
      tx_sel   = '0;
      pick_len = '0;
      for (int i = 0; i < N; i++) begin
         if (IW'(i) == ptr_q) tx_sel = TX_BYTE[i*8 +: 8];
         if (IW'(i) == pick_idx) pick_len = LEN[i*LEN_W +: LEN_W];
      end
   end

   // Transaction sequencer: arbitration, CS framing, delays, byte handshake
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      cs_n_d        = cs_n_q;
      len_d         = len_q;
      byte_idx_d    = byte_idx_q;
      cnt_d         = cnt_q;
      ptr_d         = ptr_q;
      spi_tx_byte_d = spi_tx_byte_q;
      rx_byte_d     = rx_byte_q;
      spi_tx_dv_d   = 1'b0;
      rx_dv_d       = '0;
      done_d        = '0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               gnt_d      = pick_gnt;
               cs_n_d     = ~pick_gnt;
               len_d      = pick_len;
               byte_idx_d = '0;
               cnt_d      = SETUP_CNT;
               ptr_d      = pick_idx;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else state_d = S_SEND;
         end
         S_SEND: begin
            if (SPI_TX_READY) begin
               spi_tx_byte_d = tx_sel;
               spi_tx_dv_d   = 1'b1;
               state_d       = S_WAIT;
            end
         end
         S_WAIT: begin
            if (SPI_RX_DV) begin
               rx_byte_d = SPI_RX_BYTE;
               rx_dv_d   = gnt_q;
               if (byte_idx_q == len_q) begin
                  cs_n_d  = '1;
                  done_d  = gnt_q;
                  cnt_d   = HOLD_CNT;
                  state_d = S_HOLD;
               end else begin
                  cnt_d   = GAP_CNT;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Index moves once the client has seen RX_DV with the old one
            if (rx_dv_q != '0) byte_idx_d = byte_idx_q + 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else state_d = S_SEND;
         end
         S_HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               gnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         gnt_q         <= '0;
         cs_n_q        <= '1;
         len_q         <= '0;
         byte_idx_q    <= '0;
         cnt_q         <= '0;
         ptr_q         <= IW'(N - 1);
         spi_tx_byte_q <= '0;
         rx_byte_q     <= '0;
         spi_tx_dv_q   <= 1'b0;
         rx_dv_q       <= '0;
         done_q        <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         cs_n_q        <= cs_n_d;
         len_q         <= len_d;
         byte_idx_q    <= byte_idx_d;
         cnt_q         <= cnt_d;
         ptr_q         <= ptr_d;
         spi_tx_byte_q <= spi_tx_byte_d;
         rx_byte_q     <= rx_byte_d;
         spi_tx_dv_q   <= spi_tx_dv_d;
         rx_dv_q       <= rx_dv_d;
         done_q        <= done_d;
      end
   end

   // Chip selects release the instant reset is seen
   assign CS_n        = cs_n_q | {N{RST}};
   assign GNT         = gnt_q;
   assign BYTE_INDEX  = byte_idx_q;
   assign RX_DV       = rx_dv_q;
   assign RX_BYTE     = rx_byte_q;
   assign DONE        = done_q;
   assign SPI_TX_BYTE = spi_tx_byte_q;
   assign SPI_TX_DV   = spi_tx_dv_q;

endmodule
